pulp_io_apb_initiator: RTL and testbench
========================================

// Module: pulp_io_apb_initiator
// PURPOSE
//  APB initiator driving the two APB completer ports of pulp_io (uDMA cfg, GPIO) from a
//  valid/ready command stream. One outstanding transfer, target selected per command,
//  PREADY watchdog with error response. Used by the SoC cfg bridge and by the standalone IO testbench.
// PARAMETERS
//  APB_ADDR_WIDTH  12   width of paddr on both completer ports
//  TIMEOUT_CYCLES  256  max ACCESS cycles waiting for PREADY; 0 = watchdog disabled
// PORTS
//  sys_clk_i          in   1               single clock
//  sys_rst_i          in   1               synchronous reset, active-high
//  req_valid_i        in   1               command valid
//  req_ready_o        out  1               command accepted when valid&ready
//  req_target_i       in   1               apb_tgt_e: 0 = uDMA, 1 = GPIO
//  req_write_i        in   1               1 = write, 0 = read
//  req_addr_i         in   APB_ADDR_WIDTH  byte address
//  req_wdata_i        in   32              write data
//  rsp_valid_o        out  1               response valid
//  rsp_ready_i        in   1               response consumed when valid&ready
//  rsp_rdata_o        out  32              read data (0 for writes and on timeout)
//  rsp_err_o          out  1               PSLVERR or watchdog timeout
//  udma_apb_paddr/pwdata/pwrite/psel/penable  out  APB_ADDR_WIDTH/32/1/1/1
//  udma_apb_prdata/pready/pslverr             in   32/1/1
//  gpio_apb_paddr/pwdata/pwrite/psel/penable  out  APB_ADDR_WIDTH/32/1/1/1
//  gpio_apb_prdata/pready/pslverr             in   32/1/1
// BEHAVIOUR
//  - One clock, sys_clk_i; reset synchronous active-high (sys_rst_i). All outputs registered except req_ready_o.
//  - Reset: state IDLE; all psel/penable/pwrite 0, paddr/pwdata 0; rsp_valid_o 0, rsp_rdata_o 0,
//    rsp_err_o 0; watchdog counter 0. Reset mid-transfer drops psel/penable next edge, no response issued.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//    IDLE: req_ready_o = 1 (only here). On valid&ready latch target/write/addr/wdata -> SETUP.
//    SETUP: selected psel=1, penable=0, one cycle -> ACCESS.
//    ACCESS: selected psel=1, penable=1; wait for selected pready. On pready: capture
//      prdata (reads; 0 for writes) and pslverr into rsp regs, drop psel/penable -> RESP.
//    RESP: rsp_valid_o=1, held stable until rsp_ready_i -> IDLE.
//  - Latency: accept at edge 0, SETUP cycle 1, ACCESS cycle 2; pready in cycle 2 gives
//    rsp_valid_o in cycle 3. Min 4 cycles per transfer incl. IDLE (no back-to-back overlap).
//  - Unselected port: psel=penable=0 always. paddr/pwdata/pwrite driven from the latched
//    command on both ports; held stable from SETUP through ACCESS.
//  - pready/pslverr/prdata of the unselected port are ignored, including in ACCESS.
//  - pready sampled only in ACCESS; pready high during SETUP has no effect.
//  - Watchdog (TIMEOUT_CYCLES>0): counter clears on entering ACCESS, +1 each ACCESS cycle
//    without pready; on reaching TIMEOUT_CYCLES-1 with pready still low -> abort: psel/penable
//    drop next edge, rsp_err_o=1, rsp_rdata_o=0 -> RESP. Pready in that same final cycle wins (normal completion).
//    Counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps. TIMEOUT_CYCLES=0: wait forever.
//  - rsp_err_o = pslverr of selected port OR timeout; rdata still captured on pslverr reads.
//  - req_* inputs ignored outside IDLE; rsp_ready_i ignored outside RESP.
// STRUCTURE
//  - pulp_io_pkg: typedef enum logic {APB_TGT_UDMA=1'b0, APB_TGT_GPIO=1'b1} apb_tgt_e;
//    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS, APB_RESP} apb_init_state_e.
//  - Single module; no sub-module. Watchdog counter and port muxing inline.
// TESTING
//  1 Write uDMA addr 0x010 data 0xA5A5_0001, completer pready in 1st ACCESS -> udma psel 2 cycles,
//    penable 1 cycle, gpio psel never high, rsp_valid cycle 3, err 0, rdata 0.
//  2 Read GPIO addr 0x004, pready after 3 wait states, prdata 0x0000_00F0 -> rsp_rdata 0xF0,
//    err 0; paddr/pwrite stable all ACCESS cycles.
//  3 TIMEOUT_CYCLES=8, GPIO never asserts pready -> psel drops after 8 ACCESS cycles,
//    rsp_err 1, rdata 0; pready arriving later ignored.
//  4 uDMA read with pslverr=1, prdata 0x1234 -> rsp_err 1, rsp_rdata 0x1234; rsp_ready held
//    low 5 cycles -> rsp_valid/data stable, req_ready 0 throughout.
//  5 sys_rst_i pulsed in ACCESS -> next edge psel/penable 0, rsp_valid 0, req_ready 1;
//    following command completes normally.
//  6 Unselected-port pready/pslverr toggled randomly during 50 back-to-back mixed-target
//    transfers -> responses match scoreboard, one psel high at a time.

Source files
------------

// File: rtl/pulp_io_pkg.sv
// Shared types for the pulp_io APB initiator.
//   apb_tgt_e        : which APB completer a command addresses (uDMA cfg or GPIO)
//   apb_init_state_e : APB initiator transfer phases
package pulp_io_pkg;

  typedef enum logic {
    APB_TGT_UDMA = 1'b0,
    APB_TGT_GPIO = 1'b1
  } apb_tgt_e;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS,
    APB_RESP
  } apb_init_state_e;

endpackage

// File: rtl/pulp_io_apb_initiator.sv
// APB initiator for the two pulp_io completer ports (uDMA cfg, GPIO).
// Accepts one command at a time on a valid/ready stream, runs a single APB
// transfer on the selected port and returns the result on a valid/ready
// response stream. A PREADY watchdog turns a stuck completer into an error.
//
// Ports
//   sys_clk_i, sys_rst_i          clock, synchronous active-high reset
//   req_valid_i / req_ready_o     command handshake (ready only when idle)
//   req_target_i                  0 = uDMA, 1 = GPIO
//   req_write_i, req_addr_i, req_wdata_i   command fields
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_rdata_o, rsp_err_o        read data, PSLVERR-or-timeout flag
//   udma_apb_*, gpio_apb_*        APB completer ports
//
// Parameters
//   APB_ADDR_WIDTH  paddr width on both ports
//   TIMEOUT_CYCLES  max ACCESS cycles without PREADY; 0 disables the watchdog
module pulp_io_apb_initiator
  import pulp_io_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_target_i,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] udma_apb_paddr,
  output logic [31:0]               udma_apb_pwdata,
  output logic                      udma_apb_pwrite,
  output logic                      udma_apb_psel,
  output logic                      udma_apb_penable,
  input  logic [31:0]               udma_apb_prdata,
  input  logic                      udma_apb_pready,
  input  logic                      udma_apb_pslverr,
  output logic [APB_ADDR_WIDTH-1:0] gpio_apb_paddr,
  output logic [31:0]               gpio_apb_pwdata,
  output logic                      gpio_apb_pwrite,
  output logic                      gpio_apb_psel,
  output logic                      gpio_apb_penable,
  input  logic [31:0]               gpio_apb_prdata,
  input  logic                      gpio_apb_pready,
  input  logic                      gpio_apb_pslverr
);

  // Counter must hold TIMEOUT_CYCLES; keep at least one bit when disabled.
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  apb_init_state_e           state_reg, state_next;
  apb_tgt_e                  tgt_reg, tgt_next;
  logic                      write_reg, write_next;
  logic [APB_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [31:0]               wdata_reg, wdata_next;
  logic                      udma_psel_reg, udma_psel_next;
  logic                      udma_penable_reg, udma_penable_next;
  logic                      gpio_psel_reg, gpio_psel_next;
  logic                      gpio_penable_reg, gpio_penable_next;
  logic                      rsp_valid_reg, rsp_valid_next;
  logic [31:0]               rsp_rdata_reg, rsp_rdata_next;
  logic                      rsp_err_reg, rsp_err_next;
  logic [CNT_W-1:0]          wd_cnt_reg, wd_cnt_next;

  // Completer response of the latched target only; the other port is ignored.
  logic        sel_pready;
  logic        sel_pslverr;
  logic [31:0] sel_prdata;

  always_comb begin
    sel_pready  = (tgt_reg == APB_TGT_GPIO) ? gpio_apb_pready  : udma_apb_pready;
    sel_pslverr = (tgt_reg == APB_TGT_GPIO) ? gpio_apb_pslverr : udma_apb_pslverr;
    sel_prdata  = (tgt_reg == APB_TGT_GPIO) ? gpio_apb_prdata  : udma_apb_prdata;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_reg        <= APB_IDLE;
      tgt_reg          <= APB_TGT_UDMA;
      write_reg        <= 1'b0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      udma_psel_reg    <= 1'b0;
      udma_penable_reg <= 1'b0;
      gpio_psel_reg    <= 1'b0;
      gpio_penable_reg <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_rdata_reg    <= '0;
      rsp_err_reg      <= 1'b0;
      wd_cnt_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      tgt_reg          <= tgt_next;
      write_reg        <= write_next;
      addr_reg         <= addr_next;
      wdata_reg        <= wdata_next;
      udma_psel_reg    <= udma_psel_next;
      udma_penable_reg <= udma_penable_next;
      gpio_psel_reg    <= gpio_psel_next;
      gpio_penable_reg <= gpio_penable_next;
      rsp_valid_reg    <= rsp_valid_next;
      rsp_rdata_reg    <= rsp_rdata_next;
      rsp_err_reg      <= rsp_err_next;
      wd_cnt_reg       <= wd_cnt_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    tgt_next          = tgt_reg;
    write_next        = write_reg;
    addr_next         = addr_reg;
    wdata_next        = wdata_reg;
    udma_psel_next    = udma_psel_reg;
    udma_penable_next = udma_penable_reg;
    gpio_psel_next    = gpio_psel_reg;
    gpio_penable_next = gpio_penable_reg;
    rsp_valid_next    = rsp_valid_reg;
    rsp_rdata_next    = rsp_rdata_reg;
    rsp_err_next      = rsp_err_reg;
    wd_cnt_next       = wd_cnt_reg;

    unique case (state_reg)
      APB_IDLE: begin
        if (req_valid_i) begin
          tgt_next       = apb_tgt_e'(req_target_i);
          write_next     = req_write_i;
          addr_next      = req_addr_i;
          wdata_next     = req_wdata_i;
          udma_psel_next = ~req_target_i;
          gpio_psel_next = req_target_i;
          state_next     = APB_SETUP;
        end
      end
      APB_SETUP: begin
        // Only the port already selected moves into its access phase.
        udma_penable_next = udma_psel_reg;
        gpio_penable_next = gpio_psel_reg;
        wd_cnt_next       = '0;
        state_next        = APB_ACCESS;
      end
      APB_ACCESS: begin
        // PREADY in the final watchdog cycle still completes normally.
        if (sel_pready) begin
          rsp_rdata_next    = write_reg ? 32'h0 : sel_prdata;
          rsp_err_next      = sel_pslverr;
          rsp_valid_next    = 1'b1;
          udma_psel_next    = 1'b0;
          udma_penable_next = 1'b0;
          gpio_psel_next    = 1'b0;
          gpio_penable_next = 1'b0;
          state_next        = APB_RESP;
        end else if (WD_EN && (wd_cnt_reg == CNT_LAST)) begin
          rsp_rdata_next    = 32'h0;
          rsp_err_next      = 1'b1;
          rsp_valid_next    = 1'b1;
          udma_psel_next    = 1'b0;
          udma_penable_next = 1'b0;
          gpio_psel_next    = 1'b0;
          gpio_penable_next = 1'b0;
          state_next        = APB_RESP;
        end else if (wd_cnt_reg != CNT_SAT) begin
          wd_cnt_next = wd_cnt_reg + CNT_W'(1);
        end
      end
      APB_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_next = 1'b0;
          state_next     = APB_IDLE;
        end
      end
      default: state_next = APB_IDLE;
    endcase
  end

  assign req_ready_o      = (state_reg == APB_IDLE);
  assign rsp_valid_o      = rsp_valid_reg;
  assign rsp_rdata_o      = rsp_rdata_reg;
  assign rsp_err_o        = rsp_err_reg;

  // Address/data/direction go to both ports; psel decides who listens.
  assign udma_apb_paddr   = addr_reg;
  assign udma_apb_pwdata  = wdata_reg;
  assign udma_apb_pwrite  = write_reg;
  assign udma_apb_psel    = udma_psel_reg;
  assign udma_apb_penable = udma_penable_reg;
  assign gpio_apb_paddr   = addr_reg;
  assign gpio_apb_pwdata  = wdata_reg;
  assign gpio_apb_pwrite  = write_reg;
  assign gpio_apb_psel    = gpio_psel_reg;
  assign gpio_apb_penable = gpio_penable_reg;

endmodule

// File: tb/tb_pulp_io_apb_initiator.sv
// Bench for pulp_io_apb_initiator. Each transfer is described by its command
// plus completer behaviour (wait states, slverr, prdata); the expected
// waveform per cycle is derived from the transfer timeline (SETUP at +1,
// ACCESS from +2 for min(waits+1, TO) cycles, then RESP until consumed).
module tb_pulp_io_apb_initiator;

  localparam int AW = 12;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          srst;
  logic          req_valid, req_ready, req_target, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] u_paddr, g_paddr;
  logic [31:0]   u_pwdata, g_pwdata, u_prdata, g_prdata;
  logic          u_pwrite, u_psel, u_penable, u_pready, u_pslverr;
  logic          g_pwrite, g_psel, g_penable, g_pready, g_pslverr;

  always #5 clk = ~clk;

  pulp_io_apb_initiator #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk_i(clk), .sys_rst_i(srst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_target_i(req_target),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .udma_apb_paddr(u_paddr), .udma_apb_pwdata(u_pwdata), .udma_apb_pwrite(u_pwrite),
    .udma_apb_psel(u_psel), .udma_apb_penable(u_penable), .udma_apb_prdata(u_prdata),
    .udma_apb_pready(u_pready), .udma_apb_pslverr(u_pslverr),
    .gpio_apb_paddr(g_paddr), .gpio_apb_pwdata(g_pwdata), .gpio_apb_pwrite(g_pwrite),
    .gpio_apb_psel(g_psel), .gpio_apb_penable(g_penable), .gpio_apb_prdata(g_prdata),
    .gpio_apb_pready(g_pready), .gpio_apb_pslverr(g_pslverr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, written by the driver.
  logic          mon_en = 1'b0;
  logic          e_rr, e_up, e_upen, e_gp, e_gpen, e_rv, e_cb, e_w, e_cr, e_er;
  logic [AW-1:0] e_a;
  logic [31:0]   e_wd, e_rd;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_rr));
      chk("udma_psel", 32'(u_psel), 32'(e_up));
      chk("udma_penable", 32'(u_penable), 32'(e_upen));
      chk("gpio_psel", 32'(g_psel), 32'(e_gp));
      chk("gpio_penable", 32'(g_penable), 32'(e_gpen));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_cb) begin
        chk("udma_paddr", 32'(u_paddr), 32'(e_a));
        chk("gpio_paddr", 32'(g_paddr), 32'(e_a));
        chk("udma_pwrite", 32'(u_pwrite), 32'(e_w));
        chk("gpio_pwrite", 32'(g_pwrite), 32'(e_w));
        chk("udma_pwdata", u_pwdata, e_wd);
        chk("gpio_pwdata", g_pwdata, e_wd);
      end
      if (e_cr) begin
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_err", 32'(rsp_err), 32'(e_er));
      end
    end
  end

  task automatic set_exp(input logic rr, up, upen, gp, gpen, rv, cb,
                         input logic [AW-1:0] a, input logic w, input logic [31:0] wd,
                         input logic cr, input logic [31:0] rd, input logic er);
    e_rr = rr; e_up = up; e_upen = upen; e_gp = gp; e_gpen = gpen; e_rv = rv;
    e_cb = cb; e_a = a; e_w = w; e_wd = wd; e_cr = cr; e_rd = rd; e_er = er;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Selected port answers with rdy/slverr/prd; the other port gets noise or zeros.
  task automatic drive_completer(input logic tgt, input logic rdy, input logic sv,
                                 input logic [31:0] prd, input logic noise);
    logic [31:0] sd, nd;
    logic        ss, nr, ns;
    sd = rdy ? prd : $urandom;
    ss = rdy ? sv : 1'($urandom);
    nr = noise ? 1'($urandom) : 1'b0;
    ns = noise ? 1'($urandom) : 1'b0;
    nd = noise ? $urandom : 32'h0;
    if (tgt == 1'b0) begin
      u_pready = rdy; u_pslverr = ss; u_prdata = sd;
      g_pready = nr;  g_pslverr = ns; g_prdata = nd;
    end else begin
      g_pready = rdy; g_pslverr = ss; g_prdata = sd;
      u_pready = nr;  u_pslverr = ns; u_prdata = nd;
    end
  endtask

  // Actual observations of the last transfer, pinned by literal checks.
  logic [31:0] last_rdata;
  logic        last_err;
  int          first_rsp, n_upsel, n_upen, n_gpsel;

  task automatic xfer(input logic tgt, input logic wr, input logic [AW-1:0] addr,
                      input logic [31:0] wdata, input int waits, input logic slverr,
                      input logic [31:0] prdata, input int hold, input logic noise,
                      input logic setup_rdy, input int rst_at);
    int          acc, k, r;
    logic        tout, ee;
    logic [31:0] er;
    tout = (waits >= TO);
    acc  = tout ? TO : waits + 1;
    ee   = tout | slverr;
    er   = (tout | wr) ? 32'h0 : prdata;
    first_rsp = -1; n_upsel = 0; n_upen = 0; n_gpsel = 0;
    // cycle 0: idle, command offered
    req_valid = 1'b1; req_target = tgt; req_write = wr; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'($urandom);
    drive_completer(tgt, 1'b0, 1'b0, 32'h0, noise);
    set_exp(1, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
    cycle();
    for (k = 1; k <= 1 + acc; k++) begin
      if (rst_at == k) srst = 1'b1;
      n_upsel += int'(u_psel); n_upen += int'(u_penable); n_gpsel += int'(g_psel);
      // command inputs carry junk while busy
      req_valid = 1'($urandom); req_target = 1'($urandom); req_write = 1'($urandom);
      req_addr = AW'($urandom); req_wdata = $urandom; rsp_ready = 1'($urandom);
      drive_completer(tgt, (k == 1) ? setup_rdy : (!tout && (k - 2 == waits)),
                      slverr, prdata, noise);
      set_exp(0, !tgt, !tgt && (k >= 2), tgt, tgt && (k >= 2), 0, 1, addr, wr, wdata, 0, 0, 0);
      cycle();
      if (rst_at == k) begin
        srst = 1'b0; req_valid = 1'b0;
        drive_completer(tgt, 1'b0, 1'b0, 32'h0, noise);
        set_exp(1, 0, 0, 0, 0, 0, 1, '0, 0, 32'h0, 1, 32'h0, 0);
        cycle();
        return;
      end
    end
    r = 0;
    while (1) begin
      if (rsp_valid && first_rsp < 0) first_rsp = k;
      n_upsel += int'(u_psel); n_upen += int'(u_penable); n_gpsel += int'(g_psel);
      last_rdata = rsp_rdata; last_err = rsp_err;
      req_valid = 1'($urandom); req_target = 1'($urandom); req_addr = AW'($urandom);
      rsp_ready = (r >= hold);
      // a late pready on the selected port must not disturb the response
      drive_completer(tgt, 1'b1, 1'($urandom), $urandom, noise);
      set_exp(0, 0, 0, 0, 0, 1, 0, '0, 0, 0, 1, er, ee);
      cycle();
      if (r >= hold) break;
      r++; k++;
    end
  endtask

  initial begin
    srst = 1'b1; req_valid = 0; req_target = 0; req_write = 0; req_addr = '0;
    req_wdata = '0; rsp_ready = 0;
    u_pready = 0; u_pslverr = 0; u_prdata = '0;
    g_pready = 0; g_pslverr = 0; g_prdata = '0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    set_exp(1, 0, 0, 0, 0, 0, 1, '0, 0, 32'h0, 1, 32'h0, 0);
    mon_en = 1'b1;
    cycle();

    // 1: uDMA write, ready in first ACCESS cycle
    xfer(0, 1, 12'h010, 32'hA5A5_0001, 0, 0, 32'h0, 0, 0, 0, 0);
    chk("t1_udma_psel_cycles", 32'(n_upsel), 32'd2);
    chk("t1_udma_penable_cycles", 32'(n_upen), 32'd1);
    chk("t1_gpio_psel_cycles", 32'(n_gpsel), 32'd0);
    chk("t1_rsp_cycle", 32'(first_rsp), 32'd3);
    chk("t1_rdata", last_rdata, 32'h0);
    chk("t1_err", 32'(last_err), 32'd0);

    // 2: GPIO read, 3 wait states, pready glitch during SETUP
    xfer(1, 0, 12'h004, 32'h0, 3, 0, 32'h0000_00F0, 1, 0, 1, 0);
    chk("t2_rdata", last_rdata, 32'h0000_00F0);
    chk("t2_err", 32'(last_err), 32'd0);
    chk("t2_rsp_cycle", 32'(first_rsp), 32'd6);

    // 3: GPIO never ready -> watchdog after TO ACCESS cycles
    xfer(1, 0, 12'h008, 32'h0, 1000, 0, 32'hDEAD_BEEF, 2, 0, 0, 0);
    chk("t3_gpio_psel_cycles", 32'(n_gpsel), 32'd9);
    chk("t3_rdata", last_rdata, 32'h0);
    chk("t3_err", 32'(last_err), 32'd1);

    // edge: pready in the last allowed ACCESS cycle completes normally
    xfer(0, 0, 12'h00C, 32'h0, TO - 1, 0, 32'h0BAD_F00D, 0, 0, 0, 0);
    chk("tb_last_cycle_rdata", last_rdata, 32'h0BAD_F00D);
    chk("tb_last_cycle_err", 32'(last_err), 32'd0);

    // 4: uDMA read with pslverr, response back-pressured 5 cycles
    xfer(0, 0, 12'h100, 32'h0, 1, 1, 32'h0000_1234, 5, 0, 0, 0);
    chk("t4_rdata", last_rdata, 32'h0000_1234);
    chk("t4_err", 32'(last_err), 32'd1);

    // 5: reset during ACCESS, then a normal command
    xfer(0, 0, 12'h020, 32'h0, 5, 0, 32'h5555_AAAA, 0, 0, 0, 3);
    chk("t5_no_rsp", 32'(first_rsp), 32'hFFFF_FFFF);
    xfer(0, 1, 12'h024, 32'h1357_9BDF, 0, 0, 32'h0, 0, 0, 0, 0);
    chk("t5_after_rsp_cycle", 32'(first_rsp), 32'd3);
    chk("t5_after_err", 32'(last_err), 32'd0);

    // 6: mixed back-to-back traffic with unselected-port noise
    for (int i = 0; i < 50; i++) begin
      xfer(1'($urandom), 1'($urandom), AW'($urandom), $urandom,
           int'($urandom_range(0, 10)), 1'($urandom), $urandom,
           int'($urandom_range(0, 2)), 1, 1'($urandom), 0);
    end

    req_valid = 1'b0;
    drive_completer(0, 1'b0, 1'b0, 32'h0, 0);
    set_exp(1, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
